// File: rtl/pc_circuitry_pkg.sv
// Shared definitions for the PC next-address logic: Jump encodings and default widths.
package pc_circuitry_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned OFF_W_DEF  = 11;

    typedef enum logic [1:0] {
        JMP_SEQ = 2'b00,
        JMP_REL = 2'b01,
        JMP_RM  = 2'b10,
        JMP_RD  = 2'b11
    } jump_e;

endpackage

// File: rtl/pc_target_adder.sv
// Computes PC+1 and the PC-relative target; with PC_WRAP_FLAG_EN it also reports
// whether either sum left the 0..2^DATA_W-1 range.
module pc_target_adder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OFF_W  = 11
) (
    input  logic [DATA_W-1:0] pc_i,
    input  logic [OFF_W-1:0]  ins_i,
    output logic [DATA_W-1:0] inc_o,
    output logic [DATA_W-1:0] tgt_o
`ifdef PC_WRAP_FLAG_EN
    ,
    output logic              inc_wrap_o,
    output logic              tgt_wrap_o
`endif
);

    logic signed [OFF_W-1:0] ins_s;
    assign ins_s = ins_i;

`ifdef PC_WRAP_FLAG_EN
    // Two guard bits hold the true signed sum so both overflow and underflow are visible.
    logic [DATA_W:0]   inc_ext;
    logic [DATA_W+1:0] tgt_ext;
    logic [DATA_W+1:0] off_ext;

    assign off_ext    = (DATA_W+2)'(ins_s);
    assign inc_ext    = {1'b0, pc_i} + (DATA_W+1)'(1);
    assign tgt_ext    = {1'b0, inc_ext} + off_ext;
    assign inc_o      = inc_ext[DATA_W-1:0];
    assign tgt_o      = tgt_ext[DATA_W-1:0];
    assign inc_wrap_o = inc_ext[DATA_W];
    assign tgt_wrap_o = |tgt_ext[DATA_W+1:DATA_W];
`else
    logic [DATA_W-1:0] off;

    assign off   = DATA_W'(ins_s);
    assign inc_o = pc_i + DATA_W'(1);
    assign tgt_o = inc_o + off;
`endif

endmodule

// File: rtl/pc_circuitry.sv
// Next-PC select mux plus the registered PC+1 link value. Optional output pc_wrap is
// enabled by defining PC_WRAP_FLAG_EN.
module pc_circuitry
    import pc_circuitry_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OFF_W  = OFF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        Jump,
    input  logic              Branch,
    input  logic [DATA_W-1:0] PC,
    input  logic [OFF_W-1:0]  Ins,
    input  logic [DATA_W-1:0] Rm,
    input  logic [DATA_W-1:0] Rd,
    output logic [DATA_W-1:0] nextPC,
    output logic [DATA_W-1:0] PCplus1_mul
`ifdef PC_WRAP_FLAG_EN
    ,
    output logic              pc_wrap
`endif
);

    logic [DATA_W-1:0] inc;
    logic [DATA_W-1:0] tgt;
    logic [DATA_W-1:0] pc_plus1_d;
    logic [DATA_W-1:0] pc_plus1_q;
`ifdef PC_WRAP_FLAG_EN
    logic              inc_wrap;
    logic              tgt_wrap;
`endif

    pc_target_adder #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_adder (
        .pc_i       (PC),
        .ins_i      (Ins),
        .inc_o      (inc),
        .tgt_o      (tgt)
`ifdef PC_WRAP_FLAG_EN
        ,
        .inc_wrap_o (inc_wrap),
        .tgt_wrap_o (tgt_wrap)
`endif
    );

    // Branch is only consulted for the sequential encoding.
    always_comb begin
        nextPC = inc;
        case (Jump)
            JMP_SEQ: nextPC = Branch ? tgt : inc;
            JMP_REL: nextPC = tgt;
            JMP_RM:  nextPC = Rm;
            JMP_RD:  nextPC = Rd;
            default: nextPC = inc;
        endcase
    end

`ifdef PC_WRAP_FLAG_EN
    always_comb begin
        pc_wrap = 1'b0;
        case (Jump)
            JMP_SEQ: pc_wrap = Branch ? tgt_wrap : inc_wrap;
            JMP_REL: pc_wrap = tgt_wrap;
            default: pc_wrap = 1'b0;
        endcase
    end
`endif

    assign pc_plus1_d = inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_plus1_q <= '0;
        end else begin
            pc_plus1_q <= pc_plus1_d;
        end
    end

    assign PCplus1_mul = pc_plus1_q;

endmodule

// File: tb/tb_pc_circuitry.sv
// Self-checking bench for pc_circuitry: directed vectors, reset sequences and random
// stimulus against an integer-arithmetic reference model.
module tb_pc_circuitry;

    localparam int unsigned W  = 16;
    localparam int unsigned OW = 11;

    logic          clk;
    logic          rst;
    logic [1:0]    Jump;
    logic          Branch;
    logic [W-1:0]  PC;
    logic [OW-1:0] Ins;
    logic [W-1:0]  Rm;
    logic [W-1:0]  Rd;
    logic [W-1:0]  nextPC;
    logic [W-1:0]  PCplus1_mul;
`ifdef PC_WRAP_FLAG_EN
    logic          pc_wrap;
`endif

    int n_cmp;
    int n_fail;

    pc_circuitry #(
        .DATA_W (W),
        .OFF_W  (OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Jump        (Jump),
        .Branch      (Branch),
        .PC          (PC),
        .Ins         (Ins),
        .Rm          (Rm),
        .Rd          (Rd),
        .nextPC      (nextPC),
        .PCplus1_mul (PCplus1_mul)
`ifdef PC_WRAP_FLAG_EN
        ,
        .pc_wrap     (pc_wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [1:0]    jump;
        logic          branch;
        logic [W-1:0]  pc;
        logic [OW-1:0] ins;
        logic [W-1:0]  rm;
        logic [W-1:0]  rd;
        logic [W-1:0]  exp_next;
        logic          exp_wrap;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference model: true integer arithmetic, reduced modulo 2^W afterwards.
    function automatic longint mod_w(input longint x);
        longint m;
        m = longint'(1) << W;
        return ((x % m) + m) % m;
    endfunction

    function automatic longint true_sum(input logic [1:0] j, input logic b,
                                        input logic [W-1:0] pc, input logic [OW-1:0] ins);
        longint off;
        longint inc;
        off = ins[OW-1] ? longint'(ins) - (longint'(1) << OW) : longint'(ins);
        inc = longint'(pc) + 1;
        if (j == 2'b01 || (j == 2'b00 && b)) return inc + off;
        return inc;
    endfunction

    function automatic logic [W-1:0] model_next(input logic [1:0] j, input logic b,
                                                input logic [W-1:0] pc, input logic [OW-1:0] ins,
                                                input logic [W-1:0] rm, input logic [W-1:0] rd);
        if (j == 2'b10) return rm;
        if (j == 2'b11) return rd;
        return W'(mod_w(true_sum(j, b, pc, ins)));
    endfunction

    function automatic logic model_wrap(input logic [1:0] j, input logic b,
                                        input logic [W-1:0] pc, input logic [OW-1:0] ins);
        longint s;
        if (j[1]) return 1'b0;
        s = true_sum(j, b, pc, ins);
        return (s < 0) || (s >= (longint'(1) << W));
    endfunction

    vec_t vecs[$];

    initial begin
        logic [W-1:0] exp_reg;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        Jump   = 2'b00;
        Branch = 1'b0;
        PC     = '0;
        Ins    = '0;
        Rm     = '0;
        Rd     = '0;

        vecs.push_back('{"seq",        2'b00, 1'b0, 16'h1234, 11'h000, 16'h0, 16'h0, 16'h1235, 1'b0});
        vecs.push_back('{"fwd_br",     2'b00, 1'b1, 16'hAAAA, 11'h155, 16'h0, 16'h0, 16'hAC00, 1'b0});
        vecs.push_back('{"fwd_jmp",    2'b01, 1'bx, 16'hAAAA, 11'h155, 16'h0, 16'h0, 16'hAC00, 1'b0});
        vecs.push_back('{"back_br",    2'b00, 1'b1, 16'h0010, 11'h7FF, 16'h0, 16'h0, 16'h0010, 1'b0});
        vecs.push_back('{"br_not_tkn", 2'b00, 1'b0, 16'h0010, 11'h7FF, 16'h0, 16'h0, 16'h0011, 1'b0});
        vecs.push_back('{"jal_rm",     2'b10, 1'bx, 16'h1111, 11'h123, 16'h0055, 16'h0022, 16'h0055, 1'b0});
        vecs.push_back('{"jal_rd",     2'b11, 1'bx, 16'h1111, 11'h123, 16'h0055, 16'h0022, 16'h0022, 1'b0});
        vecs.push_back('{"wrap_inc",   2'b00, 1'b0, 16'hFFFF, 11'h000, 16'h0, 16'h0, 16'h0000, 1'b1});
        vecs.push_back('{"wrap_over",  2'b01, 1'b0, 16'hFFF0, 11'h3FF, 16'h0, 16'h0, 16'h03F0, 1'b1});
        vecs.push_back('{"wrap_under", 2'b00, 1'b1, 16'h0002, 11'h400, 16'h0, 16'h0, 16'hFC03, 1'b1});
        vecs.push_back('{"rm_no_wrap", 2'b10, 1'b1, 16'hFFFF, 11'h000, 16'hBEEF, 16'h0, 16'hBEEF, 1'b0});

        // Asynchronous reset at power-up, held across clock edges.
        #2 rst = 1'b1;
        #1 check("reset_async", PCplus1_mul, '0);
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_hold", PCplus1_mul, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release", PCplus1_mul, '0);

        foreach (vecs[i]) begin
            Jump   = vecs[i].jump;
            Branch = vecs[i].branch;
            PC     = vecs[i].pc;
            Ins    = vecs[i].ins;
            Rm     = vecs[i].rm;
            Rd     = vecs[i].rd;
            #1 check(vecs[i].name, nextPC, vecs[i].exp_next);
`ifdef PC_WRAP_FLAG_EN
            check({vecs[i].name, "_wrap"}, W'(pc_wrap), W'(vecs[i].exp_wrap));
`endif
        end

        // Sequential chaining through the link register.
        @(negedge clk);
        Jump   = 2'b00;
        Branch = 1'b0;
        PC     = 16'h1234;
        @(posedge clk);
        #1 check("seq_load", PCplus1_mul, 16'h1235);
        for (int k = 0; k < 5; k++) begin
            PC = PCplus1_mul;
            #1 check("chain_next", nextPC, W'(16'h1236 + k));
            @(posedge clk);
            #1 check("chain_reg", PCplus1_mul, W'(16'h1236 + k));
        end

        // Reset asserted mid-operation, between clock edges.
        PC = 16'h5000;
        @(negedge clk);
        rst = 1'b1;
        #1 check("mid_reset_async", PCplus1_mul, '0);
        check("mid_reset_nextpc", nextPC, 16'h5001);
        @(posedge clk);
        #1 check("mid_reset_hold", PCplus1_mul, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_reset_release", PCplus1_mul, '0);
        @(posedge clk);
        #1 check("first_load", PCplus1_mul, 16'h5001);

        // Random stimulus against the model.
        for (int k = 0; k < 300; k++) begin
            Jump   = 2'($urandom_range(0, 3));
            Branch = 1'($urandom_range(0, 1));
            PC     = (k % 10 == 0) ? W'(16'hFFFF - $urandom_range(0, 2)) : W'($urandom);
            Ins    = OW'($urandom);
            Rm     = W'($urandom);
            Rd     = W'($urandom);
            exp_reg = W'(mod_w(longint'(PC) + 1));
            #1 check("rand_next", nextPC, model_next(Jump, Branch, PC, Ins, Rm, Rd));
`ifdef PC_WRAP_FLAG_EN
            check("rand_wrap", W'(pc_wrap), W'(model_wrap(Jump, Branch, PC, Ins)));
`endif
            @(posedge clk);
            #1 check("rand_reg", PCplus1_mul, exp_reg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_circuitry.md
PC_CIRCUITRY -- requirements
Module: pc_circuitry

Interface
REQ-001 Parameter DATA_W, default 16, width of the PC, Rm, Rd, nextPC and PCplus1_mul.
REQ-002 Parameter OFF_W, default 11, width of the Ins branch-offset field.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; the only register updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 Jump  input  2  jump-mode select (00 branch/seq, 01 jmp, 10 jal Rm, 11 jal Rd).
REQ-007 Branch  input  1  take the PC-relative target when Jump=00; ignored otherwise.
REQ-008 PC  input  DATA_W  current program counter.
REQ-009 Ins  input  OFF_W  instruction offset field, two's complement.
REQ-010 Rm  input  DATA_W  register-indirect target source.
REQ-011 Rd  input  DATA_W  register-indirect target source.
REQ-012 nextPC  output  DATA_W  combinational next program counter.
REQ-013 PCplus1_mul  output  DATA_W  registered PC+1, the link/sequential value.

Function
REQ-014 inc = PC + 1, modulo 2^DATA_W.
REQ-015 tgt = inc + sign-extend(Ins) to DATA_W, modulo 2^DATA_W.
REQ-016 nextPC selection:
- Jump=00, Branch=0: nextPC = inc.
- Jump=00, Branch=1: nextPC = tgt.
- Jump=01: nextPC = tgt.
- Jump=10: nextPC = Rm.
- Jump=11: nextPC = Rd.
REQ-017 nextPC is purely combinational, zero latency, with no dependence on clk or rst.
REQ-018 An X or don't-care on Branch when Jump≠00 does not affect nextPC.
REQ-019 Each rising clk edge, PCplus1_mul loads inc; one-cycle latency; no enable.
REQ-020 Wrap-around: PC=all-ones gives inc=0; tgt overflow or underflow wraps silently.

Reset
REQ-021 rst=1 drives PCplus1_mul to 0 immediately (asynchronous), including mid-operation.
REQ-022 PCplus1_mul holds 0 while rst=1; the first load occurs on the first rising clk edge after rst deasserts.
REQ-023 nextPC is unaffected by reset.

Configuration
REQ-024 Macro PC_WRAP_FLAG_EN, when defined, adds output pc_wrap (1 bit, combinational).
REQ-025 pc_wrap = 1 when the selected nextPC computation (inc or tgt) wrapped modulo 2^DATA_W; pc_wrap = 0 for Rm/Rd selection.
REQ-026 Without PC_WRAP_FLAG_EN, the pc_wrap port and its logic do not exist; all other behaviour is identical.

Structure
REQ-027 Shared package pc_circuitry_pkg holds the Jump encodings (JMP_SEQ=00, JMP_REL=01, JMP_RM=10, JMP_RD=11) and the DATA_W/OFF_W defaults.
REQ-028 One sub-module, pc_target_adder, computes inc, tgt and the wrap indications; the top level holds the mux and the PCplus1_mul register.

Verification
REQ-029 Sequential: PC=0x1234, Jump=00, Branch=0 -> nextPC=0x1235; after a clk edge, PCplus1_mul=0x1235; chaining PC=PCplus1_mul for 5 cycles increments by 1 each cycle.
REQ-030 Forward branch: PC=0xAAAA, Ins=0x155, Jump=00, Branch=1 -> nextPC=0xAC00; Jump=01 with Branch=X -> nextPC=0xAC00.
REQ-031 Backward branch: PC=0x0010, Ins=0x7FF, Jump=00, Branch=1 -> nextPC=0x0010.
REQ-032 Indirect targets: Rm=0x0055, Jump=10 -> nextPC=0x0055; Rd=0x0022, Jump=11 -> nextPC=0x0022; Branch=X in both cases.
REQ-033 Wrap: PC=0xFFFF, Jump=00, Branch=0 -> nextPC=0x0000 and pc_wrap=1 (when enabled).
REQ-034 Reset: assert rst between clk edges -> PCplus1_mul=0 without waiting for a clock edge; deassert rst -> the next edge loads PC+1.
